instr_prefetch: RTL
===================

# instr_prefetch

Instruction prefetch unit between the core's instruction memory port (req/gnt/rvalid) and `if_stage`. Issues word-aligned sequential fetches up to a bounded number of outstanding requests. Buffers returned words in a small FIFO, each tagged with its PC, and hands them to the fetch stage over a valid/ready handshake. Flushes and redirects on branch/jump.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `MAX_OUTSTANDING`, 2: max granted-but-not-returned requests; 1..DEPTH.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_ni`  in  1  reset; asynchronous and active-low.
- `fetch_enable_i`  in  1  start fetching from `boot_addr_i` (sampled in IDLE).
- `boot_addr_i`  in  32  first fetch address; bits [1:0] ignored.
- `branch_i`  in  1  redirect request, single-cycle pulse.
- `branch_addr_i`  in  32  redirect target; bits [1:0] ignored.
- `instr_req_o`  out  1  memory request.
- `instr_gnt_i`  in  1  request accepted.
- `instr_addr_o`  out  32  request address, word aligned.
- `instr_rvalid_i`  in  1  response valid; in-order, one per grant.
- `instr_rdata_i`  in  32  response word.
- `valid_o`  out  1  instruction available to `if_stage`.
- `ready_i`  in  1  `if_stage` consumes the word.
- `rdata_o`  out  32  instruction word.
- `pc_o`  out  32  address of `rdata_o`.
- `busy_o`  out  1  outstanding requests or an ungranted request in flight.

## Operation
- FSM states:
  - IDLE → FETCH when `fetch_enable_i`=1; loads `fetch_addr_q` ← `boot_addr_i & ~3`.
  - FETCH stays FETCH. Only reset returns to IDLE.
- Issue condition in FETCH: `outstanding + fifo_count < DEPTH` and `outstanding < MAX_OUTSTANDING`.
- `instr_addr_o` = `fetch_addr_q`. On `req && gnt`: `fetch_addr_q` += 4 (mod 2^32, wraps 0xFFFFFFFC→0); `outstanding` +1.
- Once asserted, `instr_req_o` and `instr_addr_o` are held stable until `instr_gnt_i`, even across a branch.
- Each `instr_rvalid_i` decrements `outstanding`. If `discard_cnt` > 0, the word is dropped and `discard_cnt` decrements. Otherwise the word is pushed with its PC; the PC comes from a return-address register advanced by 4 per accepted response.
- Branch in cycle t:
  - FIFO cleared.
  - `discard_cnt` ← outstanding responses not yet returned, plus 1 if a request is pending ungranted in t. A grant in t also counts as outstanding.
  - `fetch_addr_q` ← `branch_addr_i & ~3`, applied after any pending request is granted.
  - Return-address register ← target.
  - The `ready_i` handshake in t is ignored; nothing is popped.
- Simultaneous push and pop with FIFO full: legal; count unchanged.
- Simultaneous `rvalid` and `branch_i`: the response is discarded.
- FIFO never overflows, by the issue condition. An `rvalid` with `outstanding`=0 is a protocol error; it is ignored, with an assertion in simulation.

## Timing
- Reset values:
  - state IDLE; `instr_req_o`=0, `instr_addr_o`=0.
  - `valid_o`=0, `rdata_o`=0, `pc_o`=0, `busy_o`=0.
  - all counters 0.
- `fetch_enable_i` at cycle t → `instr_req_o`=1 with `boot_addr_i` at t+1.
- Grant at cycle g → earliest `rvalid` at g+1.
- Response latency to `valid_o`, FIFO empty:
  - Without bypass: cycle after `rvalid`.
  - With bypass: same cycle (see Configuration).
- Branch at t → `valid_o`=0 at t+1. First new request at t+1, or the cycle after the pending ungranted request is granted.
- Back-to-back: with `gnt`=1 every cycle and 1-cycle `rvalid`, one word per cycle is sustained when `MAX_OUTSTANDING` ≥ 2.
- Reset asserted mid-operation clears everything asynchronously. Responses arriving after reset release with `outstanding`=0 are ignored.

## Configuration
- `INSTR_PREFETCH_BYPASS_EN` defined:
  - When the FIFO is empty and a non-discarded `rvalid` arrives, `valid_o`/`rdata_o`/`pc_o` are driven combinationally from `instr_rdata_i`.
  - If `ready_i`=1 the word is not pushed; otherwise it is pushed.
- Not defined: every word goes through the FIFO; minimum response→`valid_o` latency of 1 cycle; outputs come purely from registers.

## Structure
- Shared package `core_pkg`:
  - `prefetch_state_e` (IDLE, FETCH).
  - Constant `INSTR_ALIGN_MASK = 32'hFFFF_FFFC`.
  - Typedef `fetch_entry_t` {instr, pc}.
- Sub-module `fetch_fifo`: parameterised DEPTH, entry type `fetch_entry_t`, `flush_i`, push/pop, `count_o`, full/empty. The top handles the FSM, counters and bypass.

## Test plan
- Reset, `fetch_enable_i`=1 with `boot_addr_i`=0x0000_0080, `gnt`=1, 1-cycle `rvalid` → PCs 0x80, 0x84, 0x88 delivered one per cycle with `ready_i`=1.
- `ready_i`=0 with `DEPTH`=4 → exactly 4 words buffered, `instr_req_o` drops, `outstanding` never exceeds 2. Then `ready_i`=1 → in-order drain.
- `gnt` withheld 3 cycles while `branch_i` pulses to 0x200 → old address held until granted, its response discarded; next `valid_o` has `pc_o`=0x200.
- Branch with 2 outstanding responses returning as 0xAAAA_AAAA and 0xBBBB_BBBB → neither appears on `rdata_o`; first delivered `pc_o` is the target.
- `branch_addr_i`=0xFFFF_FFFE → first PC 0xFFFF_FFFC, next 0x0000_0000.
- Reset asserted with FIFO holding 3 entries → `valid_o`=0 and `busy_o`=0 immediately. A stray `rvalid` after release is ignored.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the instruction prefetch unit: FSM states, alignment mask
// and the FIFO entry that pairs an instruction word with its PC.
package core_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } prefetch_state_e;

  localparam logic [31:0] INSTR_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetch_entry_t with synchronous flush. A pop frees a
// slot in the same cycle, so push+pop while full is accepted.
module fetch_fifo
  import core_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  fetch_entry_t  data_i,
  input  logic          pop_i,
  output fetch_entry_t  data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction prefetch: sequential word fetches with bounded outstanding
// requests, PC-tagged FIFO, branch flush. Optional INSTR_PREFETCH_BYPASS_EN.
module instr_prefetch
  import core_pkg::*;
#(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_enable_i,
  input  logic [31:0] boot_addr_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        instr_req_o,
  input  logic        instr_gnt_i,
  output logic [31:0] instr_addr_o,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] rdata_o,
  output logic [31:0] pc_o,
  output logic        busy_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  prefetch_state_e state_q, state_d;
  logic [31:0]     fetch_addr_q, fetch_addr_d, ret_pc_q, ret_pc_d;
  logic [31:0]     redir_addr_q, redir_addr_d;
  logic            req_q, req_d, redir_q, redir_d;
  logic [CW-1:0]   out_q, out_d, disc_q, disc_d, fifo_cnt, cnt_nxt;
  logic            br, gnt_fire, rsp_ok, rsp_keep, push, pop;
  logic            fifo_full, fifo_empty;
  fetch_entry_t    push_entry, head;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (br),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign instr_req_o  = req_q;
  assign instr_addr_o = fetch_addr_q;
  assign busy_o       = req_q || (out_q != '0);

  always_comb begin
    br               = branch_i && (state_q == FETCH);
    gnt_fire         = req_q && instr_gnt_i;
    // Responses with nothing outstanding (e.g. from before a reset) are dropped.
    rsp_ok           = instr_rvalid_i && (out_q != '0);
    rsp_keep         = rsp_ok && (disc_q == '0) && !br;
    push_entry.instr = instr_rdata_i;
    push_entry.pc    = ret_pc_q;
    pop              = !fifo_empty && ready_i && !br;
    valid_o          = !fifo_empty;
    rdata_o          = head.instr;
    pc_o             = head.pc;
`ifdef INSTR_PREFETCH_BYPASS_EN
    push             = rsp_keep && !(fifo_empty && ready_i);
    if (rsp_keep && fifo_empty) begin
      valid_o = 1'b1;
      rdata_o = instr_rdata_i;
      pc_o    = ret_pc_q;
    end
`else
    push             = rsp_keep;
`endif
    out_d   = out_q + CW'(gnt_fire) - CW'(rsp_ok);
    cnt_nxt = br ? '0 : fifo_cnt + CW'(push) - CW'(pop);

    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    ret_pc_d     = ret_pc_q;
    redir_d      = redir_q;
    redir_addr_d = redir_addr_q;
    disc_d       = disc_q;
    req_d        = 1'b0;

    if (rsp_ok && (disc_q != '0)) disc_d = disc_q - CW'(1);
    if (rsp_keep) ret_pc_d = ret_pc_q + 32'd4;
    if (gnt_fire) begin
      fetch_addr_d = redir_q ? redir_addr_q : fetch_addr_q + 32'd4;
      redir_d      = 1'b0;
    end

    // Everything granted but not yet returned, including this cycle's grant or
    // a still-pending request, must be thrown away after a redirect.
    if (br) begin
      disc_d   = out_q - CW'(rsp_ok) + CW'(req_q);
      ret_pc_d = branch_addr_i & INSTR_ALIGN_MASK;
      if (req_q && !instr_gnt_i) begin
        redir_d      = 1'b1;
        redir_addr_d = branch_addr_i & INSTR_ALIGN_MASK;
      end else begin
        redir_d      = 1'b0;
        fetch_addr_d = branch_addr_i & INSTR_ALIGN_MASK;
      end
    end

    case (state_q)
      IDLE: if (fetch_enable_i) begin
        state_d      = FETCH;
        fetch_addr_d = boot_addr_i & INSTR_ALIGN_MASK;
        ret_pc_d     = boot_addr_i & INSTR_ALIGN_MASK;
        req_d        = 1'b1;
      end
      FETCH: begin
        if (req_q && !instr_gnt_i) req_d = 1'b1;
        else req_d = (({1'b0, out_d} + {1'b0, cnt_nxt}) < (CW+1)'(DEPTH)) &&
                     (out_d < CW'(MAX_OUTSTANDING));
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      ret_pc_q     <= '0;
      redir_addr_q <= '0;
      redir_q      <= 1'b0;
      req_q        <= 1'b0;
      out_q        <= '0;
      disc_q       <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      ret_pc_q     <= ret_pc_d;
      redir_addr_q <= redir_addr_d;
      redir_q      <= redir_d;
      req_q        <= req_d;
      out_q        <= out_d;
      disc_q       <= disc_d;
    end
  end

  // Leftover responses before fetching starts are tolerated; once fetching,
  // an unsolicited response is a memory-side protocol error.
  always @(posedge clk_i) begin
    if (rst_ni && state_q == FETCH) begin
      assert (!(instr_rvalid_i && out_q == '0))
        else $error("instr_prefetch: rvalid with no outstanding request");
      assert (!(push && fifo_full && !pop))
        else $error("instr_prefetch: push into full FIFO");
    end
  end

endmodule
